// File: rtl/pattern_pkg.sv
// Shared definitions for the 12-step pattern generator and its checker.
package pattern_pkg;

    localparam int PATTERN_W = 12;
    localparam logic [PATTERN_W-1:0] DEFAULT_PATTERN = 12'hCDC;
    localparam int CNT_W = 16;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } chkState_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] val);
        return (&val) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/sig_bit_sampler.sv
// Bit-timing recovery: synchronizes the serial input, realigns a phase
// counter on every transition and samples each bit at its midpoint.
module sig_bit_sampler #(
    parameter int BIT_CLKS = 25_000_000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iSIG,
    output logic oSAMPLE,
    output logic oBIT
);

    localparam int PH_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BIT_CLKS - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(BIT_CLKS / 2);

    logic sync1, sync2, sync3;
    logic [PH_W-1:0] phase;
    logic sigEdge;

    // sync3 only exists to see a change on the synchronized signal.
    assign sigEdge = sync2 ^ sync3;

    // Two-stage synchronizer plus the edge-detect stage.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= iSIG;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Phase restarts on each transition and free-runs through runs of equal bits.
    always_ff @(posedge iCLK) begin
        if (iRST)
            phase <= '0;
        else if (sigEdge || phase == PH_LAST)
            phase <= '0;
        else
            phase <= phase + 1'b1;
    end

    // Mid-bit strobe; the bit value holds until the next sample.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oSAMPLE <= 1'b0;
            oBIT    <= 1'b0;
        end else begin
            oSAMPLE <= !sigEdge && phase == PH_MID;
            if (!sigEdge && phase == PH_MID)
                oBIT <= sync2;
        end
    end

endmodule

// File: rtl/serial_pattern_checker.sv
// Serial pattern checker: hunts for frame alignment in the sampled stream,
// then checks every 12-bit frame and keeps saturating good/bad counts.
module serial_pattern_checker
    import pattern_pkg::*;
#(
    parameter int                    BIT_CLKS = 25_000_000,
    parameter logic [PATTERN_W-1:0]  PATTERN  = DEFAULT_PATTERN,
    parameter int                    MAX_BAD  = 2
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSIG,
    output logic             oSAMPLE,
    output logic             oBIT,
    output logic             oLOCK,
    output logic             oFRAME,
    output logic             oERR,
    output logic [CNT_W-1:0] oFRAMES,
    output logic [CNT_W-1:0] oERRS
);

    localparam int IDX_W = $clog2(PATTERN_W);
    localparam int BAD_W = $clog2(MAX_BAD + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PATTERN_W - 1);

    chkState_t state, stateNext;
    logic [PATTERN_W-1:0] window, windowNext, shifted;
    logic [IDX_W-1:0] idx, idxNext;
    logic [BAD_W-1:0] bad, badNext;
    logic frameErr, frameErrNext, errNow;
    logic [CNT_W-1:0] frameCnt, frameCntNext, errCnt, errCntNext;
    logic framePulseNext, errPulseNext;

    sig_bit_sampler #(.BIT_CLKS(BIT_CLKS)) uSampler (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iSIG    (iSIG),
        .oSAMPLE (oSAMPLE),
        .oBIT    (oBIT)
    );

    assign oLOCK   = (state == LOCK);
    assign oFRAMES = frameCnt;
    assign oERRS   = errCnt;

    // Oldest bit ends up in bit0, matching the LSB-first transmit order.
    assign shifted = {oBIT, window[PATTERN_W-1:1]};
    assign errNow  = frameErr | (oBIT != PATTERN[idx]);

    // FSM state register.
    always_ff @(posedge iCLK) begin
        if (iRST)
            state <= HUNT;
        else
            state <= stateNext;
    end

    // Next-state, frame bookkeeping and pulse decisions for each sample.
    always_comb begin
        stateNext      = state;
        windowNext     = window;
        idxNext        = idx;
        badNext        = bad;
        frameErrNext   = frameErr;
        frameCntNext   = frameCnt;
        errCntNext     = errCnt;
        framePulseNext = 1'b0;
        errPulseNext   = 1'b0;
        if (oSAMPLE) begin
            windowNext = shifted;
            if (state == HUNT) begin
                if (shifted == PATTERN) begin
                    framePulseNext = 1'b1;
                    frameCntNext   = satInc(frameCnt);
                    stateNext      = LOCK;
                    idxNext        = '0;
                    badNext        = '0;
                    frameErrNext   = 1'b0;
                end
            end else if (idx == IDX_LAST) begin
                idxNext      = '0;
                frameErrNext = 1'b0;
                if (!errNow) begin
                    framePulseNext = 1'b1;
                    frameCntNext   = satInc(frameCnt);
                    badNext        = '0;
                end else begin
                    errPulseNext = 1'b1;
                    errCntNext   = satInc(errCnt);
                    if (int'(bad) + 1 >= MAX_BAD) begin
                        // Too many bad frames in a row: drop alignment and start over clean.
                        stateNext  = HUNT;
                        windowNext = '0;
                        badNext    = '0;
                    end else begin
                        badNext = bad + 1'b1;
                    end
                end
            end else begin
                idxNext      = idx + 1'b1;
                frameErrNext = errNow;
            end
        end
    end

    // Datapath registers and the registered frame pulses.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            window   <= '0;
            idx      <= '0;
            bad      <= '0;
            frameErr <= 1'b0;
            frameCnt <= '0;
            errCnt   <= '0;
            oFRAME   <= 1'b0;
            oERR     <= 1'b0;
        end else begin
            window   <= windowNext;
            idx      <= idxNext;
            bad      <= badNext;
            frameErr <= frameErrNext;
            frameCnt <= frameCntNext;
            errCnt   <= errCntNext;
            oFRAME   <= framePulseNext;
            oERR     <= errPulseNext;
        end
    end

endmodule

// File: tb/tb_serial_pattern_checker.sv
// Directed bench for serial_pattern_checker with BIT_CLKS=8, MAX_BAD=2.
module tb_serial_pattern_checker;

    localparam int BC = 8;
    localparam logic [11:0] PAT = 12'hCDC;
    localparam logic [11:0] FLIP4 = 12'h010;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iSIG;
    logic        oSAMPLE, oBIT, oLOCK, oFRAME, oERR;
    logic [15:0] oFRAMES, oERRS;

    int total = 0;
    int bad = 0;

    serial_pattern_checker #(.BIT_CLKS(BC), .MAX_BAD(2)) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iSIG    (iSIG),
        .oSAMPLE (oSAMPLE),
        .oBIT    (oBIT),
        .oLOCK   (oLOCK),
        .oFRAME  (oFRAME),
        .oERR    (oERR),
        .oFRAMES (oFRAMES),
        .oERRS   (oERRS)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor, sampled on the falling edge.
    int cyc = 0;
    int frameCycs[$];
    int errPulses = 0;
    int bothCnt = 0;
    always @(negedge iCLK) begin
        cyc++;
        if (oFRAME) frameCycs.push_back(cyc);
        if (oERR) errPulses++;
        if (oFRAME && oERR) bothCnt++;
    end

    task automatic sendBit(input logic b);
        iSIG = b;
        repeat (BC) @(negedge iCLK);
    endtask

    task automatic sendFrame(input logic [11:0] flip);
        logic [11:0] f;
        f = PAT ^ flip;
        for (int i = 0; i < 12; i++) sendBit(f[i]);
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, "_sample"}, 32'(oSAMPLE), 0);
        chk({tag, "_bit"},    32'(oBIT),    0);
        chk({tag, "_lock"},   32'(oLOCK),   0);
        chk({tag, "_frame"},  32'(oFRAME),  0);
        chk({tag, "_err"},    32'(oERR),    0);
        chk({tag, "_frames"}, 32'(oFRAMES), 0);
        chk({tag, "_errs"},   32'(oERRS),   0);
    endtask

    initial begin
        int sampleCnt, oneBits, lockHigh, pulseHigh, gapBad;
        logic [11:0] p;

        // 1: reset, then a static low input
        iRST = 1'b1;
        iSIG = 1'b0;
        repeat (3) @(negedge iCLK);
        chkIdle("t1_rst");
        iRST = 1'b0;
        sampleCnt = 0; oneBits = 0; lockHigh = 0; pulseHigh = 0;
        repeat (200) begin
            @(negedge iCLK);
            if (oSAMPLE) sampleCnt++;
            if (oBIT) oneBits++;
            if (oLOCK) lockHigh++;
            if (oFRAME || oERR || oFRAMES != 0 || oERRS != 0) pulseHigh++;
        end
        chk("t1_samples", 32'(sampleCnt), 25);
        chk("t1_ones", 32'(oneBits), 0);
        chk("t1_lock", 32'(lockHigh), 0);
        chk("t1_quiet", 32'(pulseHigh), 0);

        // 2: start bit then five clean frames
        sendBit(1'b1);
        repeat (5) sendFrame('0);
        repeat (2) @(negedge iCLK);
        chk("t2_npulse", 32'(frameCycs.size()), 5);
        gapBad = 0;
        for (int i = 1; i < frameCycs.size(); i++)
            if (frameCycs[i] - frameCycs[i-1] != 96) gapBad++;
        chk("t2_gap", 32'(gapBad), 0);
        chk("t2_frames", 32'(oFRAMES), 5);
        chk("t2_errs", 32'(oERRS), 0);
        chk("t2_lock", 32'(oLOCK), 1);

        // 3: one corrupted frame while locked, then a good one
        sendFrame(FLIP4);
        @(negedge iCLK);
        chk("t3_err", 32'(oERR), 1);
        chk("t3_noframe", 32'(oFRAME), 0);
        chk("t3_errs", 32'(oERRS), 1);
        chk("t3_lock", 32'(oLOCK), 1);
        sendFrame('0);
        @(negedge iCLK);
        chk("t3_frame", 32'(oFRAME), 1);
        chk("t3_frames", 32'(oFRAMES), 6);

        // 4: two corrupted frames in a row drop lock; a good frame relocks
        sendFrame(FLIP4);
        @(negedge iCLK);
        chk("t4_err1", 32'(oERR), 1);
        chk("t4_lock1", 32'(oLOCK), 1);
        chk("t4_errs1", 32'(oERRS), 2);
        sendFrame(FLIP4);
        @(negedge iCLK);
        chk("t4_err2", 32'(oERR), 1);
        chk("t4_unlock", 32'(oLOCK), 0);
        chk("t4_errs2", 32'(oERRS), 3);
        sendFrame('0);
        @(negedge iCLK);
        chk("t4_relock_frame", 32'(oFRAME), 1);
        chk("t4_relock", 32'(oLOCK), 1);
        chk("t4_frames", 32'(oFRAMES), 7);

        // 5: reset mid-frame while locked, then hunt again
        p = PAT;
        for (int i = 0; i < 6; i++) sendBit(p[i]);
        iRST = 1'b1;
        @(negedge iCLK);
        chkIdle("t5_rst");
        iRST = 1'b0;
        sendFrame('0);
        @(negedge iCLK);
        chk("t5_frame", 32'(oFRAME), 1);
        chk("t5_lock", 32'(oLOCK), 1);
        chk("t5_frames", 32'(oFRAMES), 1);
        chk("t5_errs", 32'(oERRS), 0);

        // 6: preload the good-frame count near the top and run into saturation
        force dut.frameCnt = 16'hFFFE;
        @(negedge iCLK);
        release dut.frameCnt;
        for (int i = 0; i < 3; i++) begin
            sendFrame('0);
            @(negedge iCLK);
            chk($sformatf("t6_frame%0d", i), 32'(oFRAME), 1);
            chk($sformatf("t6_frames%0d", i), 32'(oFRAMES), 32'h0000FFFF);
        end

        chk("both_pulses", 32'(bothCnt), 0);
        chk("err_pulses", 32'(errPulses), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
